// File: rtl/tdm_demux_rx.sv
// Receive side of a 1-bit TDM channel-sharing link: tracks slot position from
// frame_sync and commits all N_CH recovered channel bits at once at frame end.
module tdm_demux_rx #(
    parameter int N_CH   = 4,
    parameter int SLOT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data_in,
    input  logic            data_valid,
    input  logic            frame_sync,
    output logic [N_CH-1:0] ch_out,
    output logic            frame_done,
    output logic            sync_error,
    output logic            locked
);

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
    localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [N_CH-1:0]   shadow;

    assign locked = (state == RUN);

    // Pulses default low each cycle; stalled cycles leave every register untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            slot       <= '0;
            shadow     <= '0;
            ch_out     <= '0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_error <= 1'b0;
            if (data_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow[0] <= data_in;
                            slot      <= ONE;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (frame_sync) begin
                            // An early sync restarts the frame; the partial one is dropped.
                            if (slot != '0) begin
                                sync_error <= 1'b1;
                            end
                            shadow[0] <= data_in;
                            slot      <= ONE;
                        end else if (slot == '0) begin
                            sync_error <= 1'b1;
                            state      <= HUNT;
                        end else begin
                            shadow[slot] <= data_in;
                            if (slot == LAST_SLOT) begin
                                ch_out     <= {data_in, shadow[N_CH-2:0]};
                                frame_done <= 1'b1;
                                slot       <= '0;
                            end else begin
                                slot <= slot + ONE;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx: directed vector table from the test plan,
// then random traffic compared against a frame-queue reference model.
module tb_tdm_demux_rx;

    localparam int N_CH = 4;

    logic            clk;
    logic            reset;
    logic            data_in;
    logic            data_valid;
    logic            frame_sync;
    logic [N_CH-1:0] ch_out;
    logic            frame_done;
    logic            sync_error;
    logic            locked;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux_rx #(.N_CH(N_CH), .SLOT_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .frame_done (frame_done),
        .sync_error (sync_error),
        .locked     (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            rst;
        logic            v;
        logic            s;
        logic            d;
        logic [N_CH-1:0] ch;
        logic            done;
        logic            err;
        logic            lock;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(input logic rst, input logic v, input logic s, input logic d,
                                input logic [N_CH-1:0] ch, input logic done, input logic err,
                                input logic lock);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.d = d;
        r.ch = ch; r.done = done; r.err = err; r.lock = lock;
        return r;
    endfunction

    // Reference model: a frame is the list of bits received since the last sync.
    bit              m_locked;
    bit              m_frame[$];
    logic [N_CH-1:0] m_ch;
    bit              m_done;
    bit              m_err;

    task automatic modelStep(input logic rst, input logic v, input logic s, input logic d);
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_locked = 0;
            m_frame.delete();
            m_ch = '0;
        end else if (v) begin
            if (s) begin
                if (m_locked && m_frame.size() != 0) m_err = 1;
                m_frame.delete();
                m_frame.push_back(d);
                m_locked = 1;
            end else if (m_locked) begin
                if (m_frame.size() == 0) begin
                    m_err    = 1;
                    m_locked = 0;
                end else begin
                    m_frame.push_back(d);
                    if (m_frame.size() == N_CH) begin
                        for (int k = 0; k < N_CH; k++) m_ch[k] = m_frame[k];
                        m_done = 1;
                        m_frame.delete();
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic s, input logic d);
        @(negedge clk);
        reset      = rst;
        data_valid = v;
        frame_sync = s;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkAll(input int idx, input logic [N_CH-1:0] ch, input logic done,
                            input logic err, input logic lock);
        checkOutput("ch_out", idx, int'(ch_out), int'(ch));
        checkOutput("frame_done", idx, int'(frame_done), int'(done));
        checkOutput("sync_error", idx, int'(sync_error), int'(err));
        checkOutput("locked", idx, int'(locked), int'(lock));
    endtask

    initial begin
        int cnt;
        logic r, v, s, d;

        reset = 1'b1; data_valid = 1'b0; frame_sync = 1'b0; data_in = 1'b0;

        // Reset, then clean frame 1,0,1,1
        vec.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0, 0));
        vec.push_back(mk(0, 1, 1, 1, 4'b0000, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b0000, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 1, 0, 1));
        // Back-to-back frame 0,1,1,0
        vec.push_back(mk(0, 1, 1, 0, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b0110, 1, 0, 1));
        // Frame 1,1,1,1 with a 3-cycle stall between slots 1 and 2
        vec.push_back(mk(0, 1, 1, 1, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 0, 1, 1, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 0, 0, 0, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 0, 1, 0, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b0110, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1111, 1, 0, 1));
        // Commit 1101, then early sync after two slots
        vec.push_back(mk(0, 1, 1, 1, 4'b1111, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b1111, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1111, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 1, 0, 1));
        vec.push_back(mk(0, 1, 1, 0, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 1, 0, 4'b1101, 0, 1, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1101, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b0100, 1, 0, 1));
        // Missing sync, then a fresh sync frame 0,0,0,1
        vec.push_back(mk(0, 1, 0, 1, 4'b0100, 0, 1, 0));
        vec.push_back(mk(0, 1, 0, 1, 4'b0100, 0, 0, 0));
        vec.push_back(mk(0, 1, 0, 1, 4'b0100, 0, 0, 0));
        vec.push_back(mk(0, 1, 0, 1, 4'b0100, 0, 0, 0));
        vec.push_back(mk(0, 1, 1, 0, 4'b0100, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b0100, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 0, 4'b0100, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1000, 1, 0, 1));
        // Stall between last slot and next sync keeps lock
        vec.push_back(mk(0, 0, 0, 1, 4'b1000, 0, 0, 1));
        vec.push_back(mk(0, 0, 0, 0, 4'b1000, 0, 0, 1));
        // Reset mid-frame after slot 2, then non-sync slots are ignored
        vec.push_back(mk(0, 1, 1, 1, 4'b1000, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1000, 0, 0, 1));
        vec.push_back(mk(0, 1, 0, 1, 4'b1000, 0, 0, 1));
        vec.push_back(mk(1, 1, 0, 1, 4'b0000, 0, 0, 0));
        vec.push_back(mk(0, 1, 0, 1, 4'b0000, 0, 0, 0));
        vec.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 0, 0));

        $display("[TB] directed vectors: %0d", vec.size());
        for (int i = 0; i < vec.size(); i++) begin
            applyStimulus(vec[i].rst, vec[i].v, vec[i].s, vec[i].d);
            checkAll(i, vec[i].ch, vec[i].done, vec[i].err, vec[i].lock);
        end

        // Random traffic: mostly well-formed frames with occasional sync glitches.
        applyStimulus(1, 0, 0, 0);
        modelStep(1, 0, 0, 0);
        checkAll(-1, m_ch, m_done, m_err, m_locked);
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ((cnt % N_CH) == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            d = 1'($urandom_range(0, 1));
            if (v && !r) cnt = s ? 1 : cnt + 1;
            applyStimulus(r, v, s, d);
            modelStep(r, v, s, d);
            checkAll(i, m_ch, m_done, m_err, m_locked);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive side of the 1-bit select-based channel sharing scheme: recovers N single-bit channels from one time-division-multiplexed serial line.
- The transmit side interleaves channel bits in slot order 0..N-1, marking slot 0 with frame_sync.
- The block tracks the slot position with a counter and captures each bit into a shadow register. It commits all channels atomically at frame end, so the ch_out outputs never show a partially updated frame.

Parameters:
- N_CH, 4, number of channels per frame (>= 2).
- SLOT_W, 2, slot counter width; must satisfy 2**SLOT_W >= N_CH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial TDM data bit.
- data_valid  input  1  data_in carries a slot bit this cycle; low = stall, nothing advances.
- frame_sync  input  1  qualifies slot 0; meaningful only when data_valid=1.
- ch_out  output  N_CH  committed channel values; bit k = channel k.
- frame_done  output  1  one-cycle pulse: ch_out updated this cycle.
- sync_error  output  1  one-cycle pulse: framing violation detected.
- locked  output  1  high while state = RUN.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: ch_out=0, frame_done=0, sync_error=0, locked=0, shadow=0, slot counter=0, state=HUNT.
  - Reset asserted mid-frame discards the partial frame. ch_out returns to 0.
- Qualification and latency:
  - Only cycles with data_valid=1 are slot cycles. With data_valid=0, counter, shadow, state and ch_out all hold, and both pulses are 0.
  - All outputs are registered. Effects of a slot cycle appear the cycle after the edge that samples it.
- State HUNT (locked=0):
  - Slot cycle with frame_sync=0: ignored, no error.
  - Slot cycle with frame_sync=1: shadow[0]<=data_in, slot<=1, go to RUN.
- State RUN (locked=1), slot cycle with frame_sync=0 and slot in 1..N_CH-1:
  - shadow[slot]<=data_in.
  - If slot=N_CH-1: ch_out<={data_in, shadow[N_CH-2:0]}, frame_done=1, slot<=0.
  - Otherwise slot<=slot+1.
- State RUN, slot cycle with frame_sync=1:
  - If slot=0 (expected frame start): shadow[0]<=data_in, slot<=1, no error.
  - If slot!=0 (early sync): sync_error=1. The partial frame is discarded and ch_out is unchanged. Treat the cycle as a new slot 0: shadow[0]<=data_in, slot<=1, stay in RUN.
- State RUN, slot cycle with frame_sync=0 and slot=0 (missing sync): sync_error=1, go to HUNT, no capture, ch_out unchanged.
- frame_done and sync_error are never both 1 in the same cycle.
- The slot counter never exceeds N_CH-1; it wraps to 0 only through frame completion.
- Back-to-back frames with no idle cycle must work: frame_done pulses every N_CH slot cycles.
- Stalls (data_valid=0) anywhere within a frame, including between the last slot and the next sync, are legal and do not break lock.

Test Plan:
- Reset then clean frame (N_CH=4): slot cycles with sync on the first, data 1,0,1,1 for ch0..3.
  - Expect locked=1 after the first slot and ch_out=4'b1101 with frame_done=1 one cycle after slot 3.
  - Expect ch_out=0 before that.
- Two back-to-back frames 1,0,1,1 then 0,1,1,0: frame_done pulses exactly twice, 4 cycles apart; ch_out goes 4'b1101 then 4'b0110.
- Frame 1,1,1,1 with data_valid=0 inserted for 3 cycles between slots 1 and 2:
  - Result ch_out=4'b1111, frame_done once, no sync_error.
  - ch_out unchanged during the stall.
- Early sync after a committed 4'b1101 frame: send sync+0,1 (2 slots), then sync+0,0,1,0.
  - Expect sync_error pulse on the second sync, locked stays 1, then ch_out=4'b0100.
  - ch_out stays 4'b1101 in between.
- Missing sync: after a frame, send slot cycles 1,1,1,1 with frame_sync=0.
  - Expect sync_error pulse and locked=0, ch_out unchanged.
  - Later a sync frame 0,0,0,1 gives ch_out=4'b1000.
- Reset asserted after slot 2 of a frame: next cycle ch_out=0, locked=0. Subsequent non-sync slots are ignored with no sync_error.
